// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port asynchronous SRAM arbiter.
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 19;
   localparam int SRAM_DATA_W = 8;

   // Access sequencing: address setup, strobe, hold/ack.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Round-robin pick between two requesters; returns the port index to grant.
   // A lone requester always wins; on a tie the port not granted last time wins.
   function automatic logic next_grant(input logic req0,
                                       input logic req1,
                                       input logic last_grant);
      logic grant;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else if (req1) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
      return grant;
   endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the board's single asynchronous 8-bit SRAM.
// Port 0 is the core CPU memory port, port 1 the data_io loader. Each access
// runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE. All pin-facing outputs
// are registered and track the state they belong to; the enclosing top owns
// the tristate (sram_data_io = sram_data_oe ? sram_data_o : 'z).
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int DATA_W      = SRAM_DATA_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [DATA_W-1:0] sram_data_o,
   output logic              sram_data_oe,
   input  logic [DATA_W-1:0] sram_data_i,
   output logic              sram_we_n_o,
   output logic              sram_oe_n_o
);

   // Counter is loaded with WAIT_CYCLES-1 so ACCESS lasts exactly WAIT_CYCLES.
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state_r, state_nxt;
   logic [3:0]        cnt_r, cnt_nxt;
   logic              grant_r, grant_nxt;
   logic              we_r, we_nxt;
   logic              last_grant_r, last_grant_nxt;
   logic              sel_s;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              we_n_nxt, oe_n_nxt, data_oe_nxt;
   logic              ack0_nxt, ack1_nxt, busy_nxt;

   // Next-state logic plus the pin values for the state being entered.
   always_comb begin
      state_nxt      = state_r;
      cnt_nxt        = cnt_r;
      grant_nxt      = grant_r;
      we_nxt         = we_r;
      last_grant_nxt = last_grant_r;
      addr_nxt       = sram_addr_o;
      data_nxt       = sram_data_o;
      rdata_nxt      = rdata;
      we_n_nxt       = 1'b1;
      oe_n_nxt       = 1'b1;
      data_oe_nxt    = 1'b0;
      ack0_nxt       = 1'b0;
      ack1_nxt       = 1'b0;
      sel_s          = next_grant(req0, req1, last_grant_r);

      case (state_r)
         IDLE: begin
            if (req0 || req1) begin
               grant_nxt      = sel_s;
               last_grant_nxt = sel_s;
               if (sel_s) begin
                  we_nxt   = we1;
                  addr_nxt = addr1;
                  data_nxt = wdata1;
               end else begin
                  we_nxt   = we0;
                  addr_nxt = addr0;
                  data_nxt = wdata0;
               end
               state_nxt   = SETUP;
               // SETUP: a read opens OE, a write drives data but holds WE off.
               oe_n_nxt    = we_nxt;
               data_oe_nxt = we_nxt;
            end else begin
               state_nxt = IDLE;
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            cnt_nxt     = CNT_LOAD;
            oe_n_nxt    = we_r;
            we_n_nxt    = ~we_r;
            data_oe_nxt = we_r;
         end
         ACCESS: begin
            if (cnt_r == 4'd0) begin
               state_nxt   = DONE;
               // DONE is the hold cycle: strobes off, write data still driven.
               data_oe_nxt = we_r;
               if (grant_r) begin
                  ack1_nxt = 1'b1;
               end else begin
                  ack0_nxt = 1'b1;
               end
               if (!we_r) begin
                  rdata_nxt = sram_data_i;
               end else begin
                  rdata_nxt = rdata;
               end
            end else begin
               cnt_nxt     = cnt_r - 4'd1;
               oe_n_nxt    = we_r;
               we_n_nxt    = ~we_r;
               data_oe_nxt = we_r;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State, sequencing registers and all registered outputs; reset releases the bus at once.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         grant_r      <= 1'b0;
         we_r         <= 1'b0;
         last_grant_r <= 1'b1;
         sram_addr_o  <= {ADDR_W{1'b0}};
         sram_data_o  <= {DATA_W{1'b0}};
         rdata        <= {DATA_W{1'b0}};
         sram_we_n_o  <= 1'b1;
         sram_oe_n_o  <= 1'b1;
         sram_data_oe <= 1'b0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         cnt_r        <= cnt_nxt;
         grant_r      <= grant_nxt;
         we_r         <= we_nxt;
         last_grant_r <= last_grant_nxt;
         sram_addr_o  <= addr_nxt;
         sram_data_o  <= data_nxt;
         rdata        <= rdata_nxt;
         sram_we_n_o  <= we_n_nxt;
         sram_oe_n_o  <= oe_n_nxt;
         sram_data_oe <= data_oe_nxt;
         ack0         <= ack0_nxt;
         ack1         <= ack1_nxt;
         busy         <= busy_nxt;
      end
   end

endmodule
